// File: rtl/csp_packet_sink_if.sv
// 4-phase req/ack packet link between a router
// output port and the leaf sink terminating it.
interface csp_packet_sink_if #(
  parameter int WIDTH = 11
);
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;

  modport master (
    output in_req,
    output in_data,
    input  in_ack
  );

  modport slave (
    input  in_req,
    input  in_data,
    output in_ack
  );
endinterface

// File: rtl/csp_packet_sink.sv
// Leaf packet sink: 4-phase handshake, dest check, stats.
// Optional SINK_STALL_EN adds LFSR-driven ack stalls.
module csp_packet_sink #(
  parameter int WIDTH = 11,
  parameter int MY_ID = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  csp_packet_sink_if.slave rx,
  input  logic [2:0]       src_sel,
  output logic [CNT_W-1:0] src_count,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [WIDTH-1:0] last_pkt,
  output logic [7:0]       src_seen,
  output logic             all_seen
);

  localparam logic [2:0] ID = 3'(MY_ID);
  localparam logic [7:0] OTHERS = ~(8'd1 << ID);

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    CHECK,
`ifdef SINK_STALL_EN
    STALL,
`endif
    ACK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic cap_en;
  logic chk_en;
  logic good;
  logic [2:0] pkt_src;
  logic [2:0] pkt_dst;
  logic [CNT_W-1:0] src_cnt [8];

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef SINK_STALL_EN
  logic [7:0] lfsr_q;
  logic [2:0] wait_q;
  logic       fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5]
            ^ lfsr_q[4] ^ lfsr_q[3];

  // Free-running LFSR and stall down-counter
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
      wait_q <= 3'd0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], fb};
      if (chk_en)
        wait_q <= lfsr_q[2:0] - 3'd1;
      else if (state_q == STALL)
        wait_q <= wait_q - 3'd1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:  if (!rx.in_req) state_d = IDLE;
      IDLE:  if (rx.in_req) state_d = CHECK;
`ifdef SINK_STALL_EN
      CHECK: state_d = (lfsr_q[2:0] == 3'd0)
                     ? ACK : STALL;
      STALL: if (wait_q == 3'd0) state_d = ACK;
`else
      CHECK: state_d = ACK;
`endif
      ACK:   if (!rx.in_req) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    rx.in_ack = (state_q == ACK);
    chk_en    = (state_q == CHECK);
    cap_en    = (state_q == IDLE) && rx.in_req;
  end

  assign pkt_src = last_pkt[5:3];
  assign pkt_dst = last_pkt[2:0];
  assign good    = (pkt_dst == ID) && (pkt_src != ID);

  // Capture and statistics, counters saturate
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pkt  <= '0;
      pkt_count <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
      src_seen  <= '0;
      for (int i = 0; i < 8; i++)
        src_cnt[i] <= '0;
    end else begin
      if (cap_en) last_pkt <= rx.in_data;
      if (chk_en) begin
        pkt_count <= sat_inc(pkt_count);
        if (good) begin
          src_cnt[pkt_src]  <= sat_inc(src_cnt[pkt_src]);
          src_seen[pkt_src] <= 1'b1;
        end else begin
          err_count <= sat_inc(err_count);
          err_flag  <= 1'b1;
        end
      end
    end
  end

  assign src_count = src_cnt[src_sel];
  assign all_seen  = (src_seen == OTHERS);

endmodule

// File: tb/tb_csp_packet_sink.sv
// Scoreboard bench for csp_packet_sink (MY_ID=0,
// CNT_W=4 so saturation is reachable).
module tb_csp_packet_sink;
  localparam int W  = 11;
  localparam int ID = 0;
  localparam int CW = 4;

  typedef struct packed {
    logic [10:0] pkt;
    logic [3:0]  pc;
    logic [3:0]  ec;
    logic [3:0]  sc;
    logic        ef;
    logic [7:0]  seen;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    src_sel = 3'd0;
  logic [CW-1:0] src_count;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] err_count;
  logic          err_flag;
  logic [W-1:0]  last_pkt;
  logic [7:0]    src_seen;
  logic          all_seen;

  always #5 clk = ~clk;

  csp_packet_sink_if #(.WIDTH(W)) bus();

  csp_packet_sink #(
    .WIDTH(W), .MY_ID(ID), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(bus),
    .src_sel(src_sel),
    .src_count(src_count),
    .pkt_count(pkt_count),
    .err_count(err_count),
    .err_flag(err_flag),
    .last_pkt(last_pkt),
    .src_seen(src_seen),
    .all_seen(all_seen)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic [3:0] m_pc, m_ec;
  logic       m_ef;
  logic [7:0] m_seen;
  logic [3:0] m_src [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [3:0] inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  task automatic model_clear();
    m_pc = 0; m_ec = 0; m_ef = 0; m_seen = 0;
    for (int i = 0; i < 8; i++) m_src[i] = 0;
  endtask

  task automatic raise(input logic [10:0] d,
                       output int gap);
    exp_t e;
    logic good;
    logic [2:0] s;
    @(negedge clk);
    s = d[5:3];
    bus.in_data = d;
    src_sel = s;
    bus.in_req = 1'b1;
    good = (d[2:0] == 3'(ID)) && (s != 3'(ID));
    m_pc = inc(m_pc);
    if (good) begin
      m_src[s] = inc(m_src[s]);
      m_seen[s] = 1'b1;
    end else begin
      m_ec = inc(m_ec);
      m_ef = 1'b1;
    end
    e.pkt = d; e.pc = m_pc; e.ec = m_ec;
    e.sc = m_src[s]; e.ef = m_ef; e.seen = m_seen;
    q.push_back(e);
    gap = 0;
    for (int i = 0; i < 40 && !bus.in_ack; i++) begin
      @(posedge clk);
      gap++;
      @(negedge clk);
    end
    if (!bus.in_ack) chk("ack_timeout", 0, 1);
  endtask

  task automatic drop();
    bus.in_req = 1'b0;
    for (int i = 0; i < 10 && bus.in_ack; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (bus.in_ack) chk("ack_release", 1, 0);
  endtask

  task automatic send(input logic [10:0] d,
                      output int gap);
    raise(d, gap);
    drop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_req = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compare stats on every ack rising
  logic mon_prev = 1'b0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.in_ack && !mon_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("last_pkt", 32'(last_pkt), 32'(mon_e.pkt));
          chk("pkt_count", 32'(pkt_count), 32'(mon_e.pc));
          chk("err_count", 32'(err_count), 32'(mon_e.ec));
          chk("err_flag", 32'(err_flag), 32'(mon_e.ef));
          chk("src_seen", 32'(src_seen), 32'(mon_e.seen));
          chk("src_count", 32'(src_count), 32'(mon_e.sc));
        end
      end
      mon_prev = bus.in_ack;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  int g;
  logic [10:0] d5;

  initial begin
    bus.in_req = 1'b0;
    bus.in_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.in_ack), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_flag", 32'(err_flag), 0);
    chk("rst_last", 32'(last_pkt), 0);
    chk("rst_seen", 32'(src_seen), 0);
    chk("rst_all", 32'(all_seen), 0);
    reset = 1'b0;
    @(negedge clk);

    // one good packet from each other source
    for (int s = 1; s < 8; s++)
      send({5'b10000, 3'(s), 3'b000}, g);
    @(negedge clk);
    chk("t1_pkt", 32'(pkt_count), 7);
    chk("t1_seen", 32'(src_seen), 32'hFE);
    chk("t1_all", 32'(all_seen), 1);
    chk("t1_err", 32'(err_count), 0);
    chk("t1_flag", 32'(err_flag), 0);
    for (int s = 0; s < 8; s++) begin
      src_sel = 3'(s);
      #1;
      chk("t1_srccnt", 32'(src_count), (s == 0) ? 0 : 1);
    end

    // wrong dest
    do_reset();
    send(11'b10000_001_010, g);
    @(negedge clk);
    chk("t2_err", 32'(err_count), 1);
    chk("t2_flag", 32'(err_flag), 1);
    chk("t2_pkt", 32'(pkt_count), 1);
    chk("t2_seen", 32'(src_seen), 0);
    chk("t2_last", 32'(last_pkt), 32'h40A);

    // self-send
    do_reset();
    send(11'b01100_000_000, g);
    @(negedge clk);
    chk("t3_err", 32'(err_count), 1);
    chk("t3_flag", 32'(err_flag), 1);
    chk("t3_seen0", 32'(src_seen[0]), 0);

    // saturation
    do_reset();
    for (int i = 0; i < 17; i++)
      send(11'b11111_011_000, g);
    @(negedge clk);
    src_sel = 3'd3;
    #1;
    chk("t4_srccnt", 32'(src_count), 15);
    chk("t4_pkt", 32'(pkt_count), 15);
    chk("t4_err", 32'(err_count), 0);

    // reset in ACK with req held high
    do_reset();
    d5 = 11'b00001_101_000;
    raise(d5, g);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    chk("t5_ack", 32'(bus.in_ack), 0);
    chk("t5_pkt", 32'(pkt_count), 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_ack", 32'(bus.in_ack), 0);
      chk("t5_hold_pkt", 32'(pkt_count), 0);
    end
    bus.in_req = 1'b0;
    repeat (2) @(negedge clk);
    send(d5, g);
    @(negedge clk);
    chk("t5_pkt1", 32'(pkt_count), 1);

    // back-to-back burst, latency bounds
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send({5'b00110, 3'((i % 7) + 1), 3'b000}, g);
`ifdef SINK_STALL_EN
      chk("t6_gap_range",
          32'((g >= 2) && (g <= 9)), 1);
`else
      chk("t6_gap", 32'(g), 2);
`endif
    end
    @(negedge clk);
    chk("t6_pkt", 32'(pkt_count), 15);
    chk("t6_err", 32'(err_count), 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
